wb_regfile: RTL and testbench
=============================

# wb_regfile

Writeback stage and integer register file of the pipeline: consumes the memory/writeback register outputs (ALU result, load data, destination address, write and load enables), selects the writeback value, and commits it to a 32 x 32-bit register file. Also serves the decode stage's two combinational read ports, with same-cycle write-through bypass. Keeps a retired-writeback counter for debug and test.

## Interface
- XLEN, 32, data width of every register and writeback value
- NREGS, 32, register count; address width is log2(NREGS) = 5
- CNT_W, 32, width of the retired-writeback counter
- clk  in  1  rising-edge clock; the block's only clock
- rst  in  1  asynchronous, active-high reset
- alu_data_in  in  XLEN  signed ALU result from the memory/writeback register
- load_data_in  in  XLEN  load data from the memory/writeback register
- dest_reg_addr_in  in  5  destination register address
- write_enable_in  in  1  writeback requested this cycle
- load_enable_in  in  1  1 selects load_data_in, 0 selects alu_data_in
- rs1_addr  in  5  read port 1 address
- rs2_addr  in  5  read port 2 address
- rs1_data  out  XLEN  read port 1 data, combinational
- rs2_data  out  XLEN  read port 2 data, combinational
- wb_data  out  XLEN  selected writeback value, combinational, valid every cycle
- wb_commit  out  1  registered; 1 for one cycle after a write to a register other than x0
- wb_count  out  CNT_W  registered count of committed writes

## Operation
- Writeback value: wb_data = load_enable_in ? load_data_in : alu_data_in. No sign or width manipulation; the value is passed through bit-exact.
- Commit condition: write_enable_in && dest_reg_addr_in != 0. On a rising clk edge with commit true, regs[dest_reg_addr_in] <= wb_data.
- x0: never written, always reads 0. A write to x0 is dropped: no wb_commit, no count increment.
- Reads: rsN_data = 0 if rsN_addr == 0; else wb_data if commit is true and rsN_addr == dest_reg_addr_in (write-through bypass); else regs[rsN_addr]. Both ports apply the bypass independently, including when rs1_addr == rs2_addr.
- load_enable_in with write_enable_in low has no effect.
- Counter: wb_count increments by 1 on each committed write and wraps from 2^CNT_W-1 to 0 with no flag.
- No backpressure: the block accepts one writeback every cycle and never stalls.

## Timing
- Reset (async assert, any time): regs[1..31] = 0, wb_commit = 0, wb_count = 0. Takes effect immediately and holds while rst is high. Commits in the reset-release cycle are ignored if rst is still high at the edge.
- Write latency: 1 cycle into storage. A read in the same cycle sees the new value through the bypass path (0-cycle visible). wb_commit asserts in the cycle after the commit edge.
- Back-to-back writes to the same register: the last one wins. The bypass always reflects the current cycle's input.
- Combinational path: inputs -> wb_data -> rsN_data. There is no combinational path from any input to wb_commit or wb_count.

## Structure
- Shared core package provides XLEN, REG_ADDR_W (5), and the REG_ZERO constant (5'd0). The block imports these and does not redeclare them.
- One natural sub-module: regfile_2r1w. It holds the storage array, the reset clear, the x0 rule, and the bypass.
- wb_regfile keeps the writeback mux, commit logic, wb_commit, and wb_count at its top level.

## Test plan
- Reset: assert rst mid-run after writing x5 = 0x12345678 -> x5 reads 0, wb_count = 0, wb_commit = 0 immediately (no clock edge needed).
- ALU writeback: alu_data_in = 0xFFFFFFF6, load_enable_in = 0, write_enable_in = 1, dest = 3; next cycle read x3 -> 0xFFFFFFF6, wb_commit = 1, wb_count = 1.
- Load writeback: load_data_in = 0xDEADBEEF, alu_data_in = 0x1, load_enable_in = 1, dest = 31 -> x31 = 0xDEADBEEF.
- Bypass: write 0xCAFEF00D to x7 while rs1_addr = rs2_addr = 7 in the same cycle -> both read ports show 0xCAFEF00D before the edge; old value 0 the cycle before.
- x0 and disabled writes: write_enable_in = 1, dest = 0, data 0xFFFFFFFF -> x0 reads 0, wb_count unchanged. write_enable_in = 0, dest = 4 -> x4 unchanged.
- Counter wrap (CNT_W = 4): 17 committed writes -> wb_count = 1.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// ============================================================================
// wb_regfile_pkg : shared core constants and types for writeback/regfile
// Revision 1.0
// ============================================================================
`default_nettype none

package wb_regfile_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef logic [XLEN-1:0]       xdata_t;
    typedef logic [REG_ADDR_W-1:0] raddr_t;

    // One memory/writeback register's worth of writeback request.
    typedef struct packed {
        logic   we;
        logic   le;
        raddr_t dest;
        xdata_t alu;
        xdata_t load;
    } wb_req_t;

    function automatic xdata_t wb_select(input wb_req_t req);
        return req.le ? req.load : req.alu;
    endfunction

    function automatic logic wb_commits(input wb_req_t req);
        return req.we && (req.dest != REG_ZERO);
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_regfile_regfile_2r1w.sv
// ============================================================================
// regfile_2r1w : 2-read/1-write integer register file, x0 hardwired, bypass
// Revision 1.0
// ============================================================================
`default_nettype none

module regfile_2r1w
    import wb_regfile_pkg::*;
#(
    parameter int NREGS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [REG_ADDR_W-1:0] waddr_i,
    input  logic [XLEN-1:0]       wdata_i,
    input  logic [REG_ADDR_W-1:0] raddr1_i,
    input  logic [REG_ADDR_W-1:0] raddr2_i,
    output logic [XLEN-1:0]       rdata1_o,
    output logic [XLEN-1:0]       rdata2_o
);

    // x0 has no storage; entries start at index 1.
    logic [XLEN-1:0] mem_q [1:NREGS-1];

    logic                  w_wr;
    logic [REG_ADDR_W-1:0] w_raddr [2];
    logic [XLEN-1:0]       w_rdata [2];

    assign w_wr = we_i && (waddr_i != REG_ZERO) && (int'(waddr_i) < NREGS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_wr) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign w_raddr[0] = raddr1_i;
    assign w_raddr[1] = raddr2_i;

    // Each port bypasses on its own, so rs1 == rs2 == dest sees the new value twice.
    for (genvar p = 0; p < 2; p++) begin : g_rport
        always_comb begin
            w_rdata[p] = '0;
            if (w_raddr[p] == REG_ZERO) begin
                w_rdata[p] = '0;
            end else if (w_wr && (w_raddr[p] == waddr_i)) begin
                w_rdata[p] = wdata_i;
            end else if (int'(w_raddr[p]) < NREGS) begin
                w_rdata[p] = mem_q[w_raddr[p]];
            end
        end
    end

    assign rdata1_o = w_rdata[0];
    assign rdata2_o = w_rdata[1];

endmodule

`default_nettype wire

// File: rtl/wb_regfile.sv
// ============================================================================
// wb_regfile : writeback select, commit tracking and integer register file
// Revision 1.0
// ============================================================================
`default_nettype none

module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [XLEN-1:0]       alu_data_in,
    input  logic [XLEN-1:0]       load_data_in,
    input  logic [REG_ADDR_W-1:0] dest_reg_addr_in,
    input  logic                  write_enable_in,
    input  logic                  load_enable_in,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]       rs1_data,
    output logic [XLEN-1:0]       rs2_data,
    output logic [XLEN-1:0]       wb_data,
    output logic                  wb_commit,
    output logic [CNT_W-1:0]      wb_count
);

    wb_req_t          w_req;
    logic             w_commit;
    logic             wb_commit_q, wb_commit_d;
    logic [CNT_W-1:0] wb_count_q,  wb_count_d;

    assign w_req.we   = write_enable_in;
    assign w_req.le   = load_enable_in;
    assign w_req.dest = dest_reg_addr_in;
    assign w_req.alu  = alu_data_in;
    assign w_req.load = load_data_in;

    assign wb_data  = wb_select(w_req);
    assign w_commit = wb_commits(w_req);

    regfile_2r1w #(
        .NREGS (NREGS)
    ) u_rf (
        .clk      (clk),
        .rst      (rst),
        .we_i     (w_commit),
        .waddr_i  (dest_reg_addr_in),
        .wdata_i  (wb_data),
        .raddr1_i (rs1_addr),
        .raddr2_i (rs2_addr),
        .rdata1_o (rs1_data),
        .rdata2_o (rs2_data)
    );

    // Counter wraps silently at 2^CNT_W.
    always_comb begin
        wb_commit_d = w_commit;
        wb_count_d  = wb_count_q;
        if (w_commit) begin
            wb_count_d = wb_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_commit_q <= 1'b0;
            wb_count_q  <= '0;
        end else begin
            wb_commit_q <= wb_commit_d;
            wb_count_q  <= wb_count_d;
        end
    end

    assign wb_commit = wb_commit_q;
    assign wb_count  = wb_count_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_regfile.sv
// ============================================================================
// tb_wb_regfile : randomized scoreboard bench for wb_regfile (CNT_W = 4)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_wb_regfile;

    localparam int TB_CNT_W = 4;

    logic        clk;
    logic        rst;
    logic [31:0] alu_data_in, load_data_in;
    logic [4:0]  dest_reg_addr_in, rs1_addr, rs2_addr;
    logic        write_enable_in, load_enable_in;
    logic [31:0] rs1_data, rs2_data, wb_data;
    logic        wb_commit;
    logic [TB_CNT_W-1:0] wb_count;

    wb_regfile #(
        .NREGS (32),
        .CNT_W (TB_CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .alu_data_in      (alu_data_in),
        .load_data_in     (load_data_in),
        .dest_reg_addr_in (dest_reg_addr_in),
        .write_enable_in  (write_enable_in),
        .load_enable_in   (load_enable_in),
        .rs1_addr         (rs1_addr),
        .rs2_addr         (rs2_addr),
        .rs1_data         (rs1_data),
        .rs2_data         (rs2_data),
        .wb_data          (wb_data),
        .wb_commit        (wb_commit),
        .wb_count         (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] wbd;
        logic        commit;
        logic [31:0] count;
    } exp_t;

    exp_t        sb_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;

    // Reference model: architectural register array plus counters.
    logic [31:0] m_regs [32];
    int unsigned m_count;
    bit          m_prev_commit;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // One cycle of stimulus; inputs change on the falling edge.
    task automatic drive(input bit r, input bit we, input bit le, input logic [4:0] d,
                         input logic [31:0] a, input logic [31:0] l,
                         input logic [4:0] a1, input logic [4:0] a2);
        exp_t        e;
        logic [31:0] v;
        bit          c;
        @(negedge clk);
        rst = r; write_enable_in = we; load_enable_in = le; dest_reg_addr_in = d;
        alu_data_in = a; load_data_in = l; rs1_addr = a1; rs2_addr = a2;
        if (r) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_count = 0;
            m_prev_commit = 1'b0;
        end
        v = le ? l : a;
        c = we && (d != 5'd0);
        e.wbd    = v;
        e.rs1    = (a1 == 5'd0) ? 32'h0 : (c && a1 == d) ? v : m_regs[a1];
        e.rs2    = (a2 == 5'd0) ? 32'h0 : (c && a2 == d) ? v : m_regs[a2];
        e.commit = m_prev_commit;
        e.count  = m_count;
        sb_q.push_back(e);
        if (!r && c) begin
            m_regs[d] = v;
            m_count   = (m_count + 1) % (1 << TB_CNT_W);
        end
        m_prev_commit = !r && c;
    endtask

    task automatic idle_read(input logic [4:0] a1, input logic [4:0] a2);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, a1, a2);
    endtask

    // Monitor: outputs are valid every cycle; sample well after the drive edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("rs1_data",  rs1_data, e.rs1);
                check("rs2_data",  rs2_data, e.rs2);
                check("wb_data",   wb_data,  e.wbd);
                check("wb_commit", {31'h0, wb_commit}, {31'h0, e.commit});
                check("wb_count",  {{(32-TB_CNT_W){1'b0}}, wb_count}, e.count);
            end
        end
    end

    initial begin
        logic [4:0] d, a1, a2;
        rst = 1'b1;
        alu_data_in = '0; load_data_in = '0; dest_reg_addr_in = '0;
        write_enable_in = 1'b0; load_enable_in = 1'b0; rs1_addr = '0; rs2_addr = '0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_count = 0;
        m_prev_commit = 1'b0;

        drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd3);
        idle_read(5'd5, 5'd3);

        // ALU writeback to x3, then load writeback to x31 with decoy ALU value.
        drive(1'b0, 1'b1, 1'b0, 5'd3,  32'hFFFF_FFF6, 32'h1111_1111, 5'd3, 5'd0);
        drive(1'b0, 1'b1, 1'b1, 5'd31, 32'h0000_0001, 32'hDEAD_BEEF, 5'd3, 5'd31);
        idle_read(5'd31, 5'd3);

        // Bypass: x7 reads 0 first, then both ports see the in-flight value.
        idle_read(5'd7, 5'd7);
        drive(1'b0, 1'b1, 1'b0, 5'd7, 32'hCAFE_F00D, 32'h0, 5'd7, 5'd7);
        idle_read(5'd7, 5'd7);

        // Writes to x0 drop; disabled writes (even with load select) do nothing.
        drive(1'b0, 1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 5'd0);
        drive(1'b0, 1'b0, 1'b1, 5'd4, 32'h5555_5555, 32'hAAAA_AAAA, 5'd4, 5'd0);
        idle_read(5'd0, 5'd4);

        // Back-to-back writes to x9: last wins.
        drive(1'b0, 1'b1, 1'b0, 5'd9, 32'h0000_0009, 32'h0, 5'd9, 5'd1);
        drive(1'b0, 1'b1, 1'b1, 5'd9, 32'h0, 32'h9999_0000, 5'd9, 5'd9);
        idle_read(5'd9, 5'd9);

        // Asynchronous reset mid-cycle after x5 = 0x12345678.
        drive(1'b0, 1'b1, 1'b0, 5'd5, 32'h1234_5678, 32'h0, 5'd5, 5'd0);
        idle_read(5'd5, 5'd5);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_rs1",    rs1_data, 32'h0);
        check("async_rst_count",  {{(32-TB_CNT_W){1'b0}}, wb_count}, 32'h0);
        check("async_rst_commit", {31'h0, wb_commit}, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd3);
        idle_read(5'd5, 5'd31);

        // 17 committed writes wrap the 4-bit counter to 1.
        for (int i = 0; i < 17; i++) begin
            d = 5'(1 + (i % 31));
            drive(1'b0, 1'b1, i[0], d, $urandom, $urandom, d, 5'(i));
        end
        idle_read(5'd1, 5'd17);

        // Randomized traffic with addresses biased toward collisions.
        for (int i = 0; i < 400; i++) begin
            d  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            a1 = ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 7));
            a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
            drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d,
                  $urandom, $urandom, a1, a2);
        end
        idle_read(5'd1, 5'd2);

        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clk);
        #5;
        n_checks++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
